// File: rtl/volt_chan_sched_if.sv
// Converter link and tagged result bus of the channel scheduler.
// master = scheduler side, slave = converter plus result consumer.
interface volt_chan_sched_if #(
  parameter int unsigned CH_W = 2
) ();
  logic [11:0]     conv_din;
  logic            conv_start;
  logic [19:0]     conv_dec;
  logic [7:0]      conv_sig;
  logic            res_valid;
  logic [CH_W-1:0] res_ch;
  logic [19:0]     res_dec;
  logic [7:0]      res_sig;

  modport master (
    output conv_din, conv_start, res_valid, res_ch, res_dec, res_sig,
    input  conv_dec, conv_sig
  );

  modport slave (
    input  conv_din, conv_start, res_valid, res_ch, res_dec, res_sig,
    output conv_dec, conv_sig
  );
endinterface

// File: rtl/volt_chan_sched.sv
// Round-robin scheduler sharing one fixed-latency voltage converter among N_CH ADC channels.
// One pending sample per channel, one issue per cycle, results returned tagged by channel.
module volt_chan_sched #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned CONV_LAT = 4
) (
  input  logic               ad_clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_CH-1:0]    smp_valid,
  input  logic [N_CH*12-1:0] smp_data,
  input  logic               ovr_clr,
  output logic [N_CH-1:0]    ovr,
  output logic               busy,
  volt_chan_sched_if.master  bus
);

  localparam logic [CH_W-1:0] RrInit = CH_W'(N_CH - 1);

  // Pending slots
  logic [11:0]     pending_q [N_CH];
  logic [N_CH-1:0] full_q, full_d;
  logic [N_CH-1:0] ovr_q, ovr_d, ovr_set;

  // Arbitration
  logic [CH_W-1:0] rr_q, rr_d;
  logic [CH_W-1:0] cand;
  logic            gnt_vld;
  logic [CH_W-1:0] gnt_ch;
  logic [N_CH-1:0] gnt_oh;

  // Issue stage
  logic            conv_start_q, conv_start_d;
  logic [11:0]     conv_din_q, conv_din_d;
  logic [CH_W-1:0] issue_ch_q, issue_ch_d;

  // In-flight tags
  logic [CONV_LAT-1:0] tag_vld_q;
  logic [CH_W-1:0]     tag_ch_q [CONV_LAT];
  logic                tag_mature;

  // Result stage
  logic            res_valid_q;
  logic [CH_W-1:0] res_ch_q;
  logic [19:0]     res_dec_q;
  logic [7:0]      res_sig_q;

  // First full slot after the last grant, wrapping at N_CH-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= N_CH; i++) begin
      cand = CH_W'((32'(rr_q) + i) % N_CH);
      if (en && !gnt_vld && full_q[cand]) begin
        gnt_vld = 1'b1;
        gnt_ch  = cand;
      end
    end
  end

  always_comb begin
    gnt_oh = gnt_vld ? (N_CH'(1) << gnt_ch) : '0;
    rr_d   = gnt_vld ? gnt_ch : rr_q;
  end

  // A capture on the slot being granted refills it without counting as an overrun.
  always_comb begin
    full_d  = (full_q & ~gnt_oh) | smp_valid;
    ovr_set = smp_valid & full_q & ~gnt_oh;
    ovr_d   = (ovr_q & ~{N_CH{ovr_clr}}) | ovr_set;
  end

  always_comb begin
    conv_start_d = gnt_vld;
    conv_din_d   = gnt_vld ? pending_q[gnt_ch] : conv_din_q;
    issue_ch_d   = gnt_vld ? gnt_ch : issue_ch_q;
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        pending_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (smp_valid[k]) begin
          pending_q[k] <= smp_data[12*k +: 12];
        end
      end
    end
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      full_q       <= '0;
      ovr_q        <= '0;
      rr_q         <= RrInit;
      conv_start_q <= 1'b0;
      conv_din_q   <= '0;
      issue_ch_q   <= '0;
    end else begin
      full_q       <= full_d;
      ovr_q        <= ovr_d;
      rr_q         <= rr_d;
      conv_start_q <= conv_start_d;
      conv_din_q   <= conv_din_d;
      issue_ch_q   <= issue_ch_d;
    end
  end

  // Tag pipe runs in lockstep with the converter; reset drops everything in flight.
  always_ff @(posedge ad_clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < int'(CONV_LAT); i++) begin
        tag_ch_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= conv_start_q;
      tag_ch_q[0]  <= issue_ch_q;
      for (int i = 1; i < int'(CONV_LAT); i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_ch_q[i]  <= tag_ch_q[i-1];
      end
    end
  end

  assign tag_mature = tag_vld_q[CONV_LAT-1];

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_dec_q   <= '0;
      res_sig_q   <= '0;
    end else begin
      res_valid_q <= tag_mature;
      if (tag_mature) begin
        res_ch_q  <= tag_ch_q[CONV_LAT-1];
        res_dec_q <= bus.conv_dec;
        res_sig_q <= bus.conv_sig;
      end
    end
  end

  always_comb begin
    bus.conv_din   = conv_din_q;
    bus.conv_start = conv_start_q;
    bus.res_valid  = res_valid_q;
    bus.res_ch     = res_ch_q;
    bus.res_dec    = res_dec_q;
    bus.res_sig    = res_sig_q;
    ovr            = ovr_q;
    busy           = (|full_q) | (|tag_vld_q) | conv_start_q;
  end

endmodule

// File: tb/tb_volt_chan_sched.sv
// Directed bench for volt_chan_sched with a behavioural fixed-latency converter model.
module tb_volt_chan_sched;
  localparam int unsigned N_CH     = 4;
  localparam int unsigned CH_W     = 2;
  localparam int unsigned CONV_LAT = 4;

  logic               ad_clk = 1'b0;
  logic               rst;
  logic               en;
  logic [N_CH-1:0]    smp_valid;
  logic [N_CH*12-1:0] smp_data;
  logic               ovr_clr;
  logic [N_CH-1:0]    ovr;
  logic               busy;

  volt_chan_sched_if #(.CH_W(CH_W)) bus ();

  volt_chan_sched #(
    .N_CH    (N_CH),
    .CH_W    (CH_W),
    .CONV_LAT(CONV_LAT)
  ) dut (
    .ad_clk   (ad_clk),
    .rst      (rst),
    .en       (en),
    .smp_valid(smp_valid),
    .smp_data (smp_data),
    .ovr_clr  (ovr_clr),
    .ovr      (ovr),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 ad_clk = ~ad_clk;

  int cyc = 0;
  always @(posedge ad_clk) cyc <= cyc + 1;

  // Converter model: |code| * 5000 / 2048 mV in BCD; non-start slots carry junk.
  function automatic logic [19:0] to_bcd(input logic [11:0] code);
    int v;
    int mv;
    logic [19:0] r;
    v = int'($signed(code));
    if (v < 0) v = -v;
    mv = v * 5000 / 2048;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(mv % 10);
      mv = mv / 10;
    end
    return r;
  endfunction

  logic [19:0] cm_dec [CONV_LAT];
  logic [7:0]  cm_sig [CONV_LAT];

  always @(posedge ad_clk) begin
    cm_dec[0] <= bus.conv_start ? to_bcd(bus.conv_din) : 20'hAAAAA;
    cm_sig[0] <= bus.conv_start ? (bus.conv_din[11] ? 8'd45 : 8'd43) : 8'h3F;
    for (int i = 1; i < int'(CONV_LAT); i++) begin
      cm_dec[i] <= cm_dec[i-1];
      cm_sig[i] <= cm_sig[i-1];
    end
  end

  assign bus.conv_dec = cm_dec[CONV_LAT-1];
  assign bus.conv_sig = cm_sig[CONV_LAT-1];

  // Event log of issues and results
  int iss_cyc [$];
  int iss_din [$];
  int res_cyc [$];
  int res_ch  [$];
  int res_dec [$];
  int res_sig [$];

  always @(negedge ad_clk) begin
    if (bus.conv_start) begin
      iss_cyc.push_back(cyc);
      iss_din.push_back(int'(bus.conv_din));
    end
    if (bus.res_valid) begin
      res_cyc.push_back(cyc);
      res_ch.push_back(int'(bus.res_ch));
      res_dec.push_back(int'(bus.res_dec));
      res_sig.push_back(int'(bus.res_sig));
    end
  end

  int n_checks = 0;
  int n_errs   = 0;
  int c0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ad_clk);
    #1;
  endtask

  task automatic clear_log();
    iss_cyc.delete(); iss_din.delete();
    res_cyc.delete(); res_ch.delete(); res_dec.delete(); res_sig.delete();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_conv_din"},   32'(bus.conv_din),   32'h0);
    check({pfx, "_conv_start"}, 32'(bus.conv_start), 32'h0);
    check({pfx, "_res_valid"},  32'(bus.res_valid),  32'h0);
    check({pfx, "_res_ch"},     32'(bus.res_ch),     32'h0);
    check({pfx, "_res_dec"},    32'(bus.res_dec),    32'h0);
    check({pfx, "_res_sig"},    32'(bus.res_sig),    32'h0);
    check({pfx, "_ovr"},        32'(ovr),            32'h0);
    check({pfx, "_busy"},       32'(busy),           32'h0);
  endtask

  logic [11:0] da [N_CH];
  logic [11:0] db [N_CH];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; smp_valid = '0; smp_data = '0; ovr_clr = 1'b0;
    da[0] = 12'h010; da[1] = 12'h111; da[2] = 12'h222; da[3] = 12'h333;
    db[0] = 12'h044; db[1] = 12'h155; db[2] = 12'h266; db[3] = 12'h377;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge ad_clk);
    check_reset_outputs("rst0");

    // 1: single sample on ch1
    tick();
    clear_log();
    en = 1'b1;
    c0 = cyc;
    smp_valid = 4'b0010; smp_data[23:12] = 12'h7FF;
    tick();
    smp_valid = '0;
    @(negedge ad_clk);
    check("t1_busy", 32'(busy), 32'h1);
    repeat (10) tick();
    check("t1_iss_n",   iss_din.size(), 1);
    check("t1_iss_din", iss_din[0], 32'h7FF);
    check("t1_iss_cyc", iss_cyc[0], c0 + 2);
    check("t1_res_n",   res_cyc.size(), 1);
    check("t1_res_cyc", res_cyc[0], c0 + 7);
    check("t1_res_ch",  res_ch[0], 1);
    check("t1_res_dec", res_dec[0], 32'h04997);
    check("t1_res_sig", res_sig[0], 43);

    // 2: fairness, two rounds with rr wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
    c0 = cyc;
    smp_valid = 4'hF;
    for (int k = 0; k < 4; k++) smp_data[12*k +: 12] = da[k];
    tick();
    smp_valid = '0;
    repeat (5) tick();
    smp_valid = 4'hF;
    for (int k = 0; k < 4; k++) smp_data[12*k +: 12] = db[k];
    tick();
    smp_valid = '0;
    repeat (12) tick();
    check("t2_iss_n", iss_din.size(), 8);
    check("t2_res_n", res_ch.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_a_din%0d", i), iss_din[i], 32'(da[i]));
      check($sformatf("t2_a_cyc%0d", i), iss_cyc[i], c0 + 2 + i);
      check($sformatf("t2_b_din%0d", i), iss_din[4+i], 32'(db[i]));
      check($sformatf("t2_b_cyc%0d", i), iss_cyc[4+i], c0 + 8 + i);
      check($sformatf("t2_a_ch%0d", i), res_ch[i], i);
      check($sformatf("t2_b_ch%0d", i), res_ch[4+i], i);
    end

    // 3: overrun on ch2, then clear, then clear racing a new overrun
    clear_log();
    en = 1'b0;
    smp_valid = 4'b0100; smp_data[35:24] = 12'h800;
    tick();
    smp_data[35:24] = 12'h001;
    tick();
    smp_valid = '0;
    @(negedge ad_clk);
    check("t3_ovr_set", 32'(ovr), 32'h4);
    check("t3_held",    iss_din.size(), 0);
    tick();
    en = 1'b1;
    repeat (10) tick();
    check("t3_iss_n",   iss_din.size(), 1);
    check("t3_iss_din", iss_din[0], 32'h001);
    check("t3_res_dec", res_dec[0], 32'h00002);
    check("t3_res_sig", res_sig[0], 43);
    check("t3_ovr_sticky", 32'(ovr), 32'h4);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    @(negedge ad_clk);
    check("t3_ovr_clr", 32'(ovr), 32'h0);
    tick();
    en = 1'b0;
    smp_valid = 4'b0100; smp_data[35:24] = 12'h00A;
    tick();
    smp_data[35:24] = 12'h00B;
    ovr_clr = 1'b1;
    tick();
    smp_valid = '0;
    ovr_clr = 1'b0;
    @(negedge ad_clk);
    check("t3_set_wins", 32'(ovr), 32'h4);
    tick();
    en = 1'b1;
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    repeat (10) tick();
    check("t3_ovr_final", 32'(ovr), 32'h0);

    // 4: ch0 granted in the same cycle a new sample arrives
    clear_log();
    en = 1'b0;
    smp_valid = 4'b0001; smp_data[11:0] = 12'h123;
    tick();
    en = 1'b1;
    smp_data[11:0] = 12'hFFF;
    tick();
    smp_valid = '0;
    repeat (12) tick();
    check("t4_iss_n",    iss_din.size(), 2);
    check("t4_iss_old",  iss_din[0], 32'h123);
    check("t4_iss_new",  iss_din[1], 32'hFFF);
    check("t4_iss_gap",  iss_cyc[1] - iss_cyc[0], 1);
    check("t4_ovr",      32'(ovr), 32'h0);
    check("t4_res_n",    res_sig.size(), 2);
    check("t4_dec_old",  res_dec[0], 32'h00710);
    check("t4_sig_old",  res_sig[0], 43);
    check("t4_dec_new",  res_dec[1], 32'h00002);
    check("t4_sig_new",  res_sig[1], 45);
    check("t4_ch_new",   res_ch[1], 0);

    // 5: ch3 strobed every cycle
    clear_log();
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      smp_valid = 4'b1000;
      smp_data[47:36] = 12'h300 + 12'(i);
      tick();
    end
    smp_valid = '0;
    repeat (12) tick();
    check("t5_iss_n", iss_din.size(), 10);
    check("t5_res_n", res_ch.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t5_din%0d", i), iss_din[i], 32'h300 + i);
      check($sformatf("t5_icyc%0d", i), iss_cyc[i], c0 + 2 + i);
      check($sformatf("t5_rcyc%0d", i), res_cyc[i], c0 + 7 + i);
      check($sformatf("t5_ch%0d", i), res_ch[i], 3);
    end
    check("t5_dec0", res_dec[0], 32'h01875);
    check("t5_ovr",  32'(ovr), 32'h0);

    // 6: reset with three conversions in flight
    clear_log();
    c0 = cyc;
    smp_valid = 4'b0111;
    for (int k = 0; k < 3; k++) smp_data[12*k +: 12] = da[k];
    tick();
    smp_valid = '0;
    repeat (4) tick();
    @(negedge ad_clk);
    check("t6_pre_busy", 32'(busy), 32'h1);
    check("t6_pre_iss",  iss_din.size(), 3);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge ad_clk);
    check_reset_outputs("t6");
    tick();
    clear_log();
    repeat (12) tick();
    check("t6_no_res", res_ch.size(), 0);
    check("t6_no_iss", iss_din.size(), 0);
    check("t6_idle",   32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
